// File: rtl/core_fetch_redirect_ctrl.sv
// Fetch sequencer: owns the PC, keeps at most one imem request in flight,
// squashes wrong-path responses on redirect and holds one word under stall.
module core_fetch_redirect_ctrl #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
  parameter int                    FLUSH_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  stall_i,
  input  logic                  br_valid_i,
  input  logic                  branch_i,
  input  logic                  jump_i,
  input  logic [DATA_WIDTH-1:0] brj_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic                  flush_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DROP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] word;
  } slot_t;

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  slot_t                 out_q, out_d;
  slot_t                 skid_q, skid_d;
  slot_t                 rsp;
  logic                  out_vld_q, out_vld_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [2:0]            flush_cnt_q, flush_cnt_d;
  logic                  redir, gnt_eff, deliver;
  logic [DATA_WIDTH-1:0] target, pc_inc;
  logic                  unused_brj_lsb;

  assign redir          = br_valid_i & (branch_i | jump_i) & ~stall_i;
  assign target         = {brj_pc_i[DATA_WIDTH-1:2], 2'b00};
  assign unused_brj_lsb = ^brj_pc_i[1:0];
  assign pc_inc         = pc_q + DATA_WIDTH'(4);

  // A full skid buffer blocks new requests, so a delivery never meets a full skid.
  assign imem_req_o = (state_q == S_REQ) & ~skid_vld_q;
  assign gnt_eff    = imem_req_o & imem_gnt_i;

  assign rsp.pc   = req_pc_q;
  assign rsp.word = imem_rdata_i;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    deliver  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (gnt_eff) begin
          if (redir) begin
            state_d = S_DROP;
          end else begin
            state_d  = S_RESP;
            pc_d     = pc_inc;
            req_pc_d = pc_q;
          end
        end
      end
      S_RESP: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          deliver = ~redir;
        end else if (redir) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (redir) pc_d = target;
  end

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (redir) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!stall_i) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (deliver) begin
        out_d     = rsp;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (deliver) begin
      // Under stall an empty output slot may still be filled directly.
      if (out_vld_q) begin
        skid_d     = rsp;
        skid_vld_d = 1'b1;
      end else begin
        out_d     = rsp;
        out_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redir)                   flush_cnt_d = FLUSH_LD;
    else if (flush_cnt_q != '0)  flush_cnt_d = flush_cnt_q - 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = out_vld_q;
  assign instr_o       = out_q.word;
  assign instr_pc_o    = out_q.pc;
  assign flush_o       = (flush_cnt_q != '0);

endmodule

// File: tb/tb_core_fetch_redirect_ctrl.sv
// Bench for core_fetch_redirect_ctrl: two instances (1- and 3-cycle flush) on
// shared stimulus, a queue-based fetch model and directed literal checks.
module tb_core_fetch_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'h0;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rstn_i, stall_i, br_valid_i, branch_i, jump_i;
  logic [31:0] brj_pc_i;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  logic        req_a, iv_a, flush_a, req_b, iv_b, flush_b;
  logic [31:0] addr_a, instr_a, ipc_a, pc_a, addr_b, instr_b, ipc_b, pc_b;

  core_fetch_redirect_ctrl #(.DATA_WIDTH(32), .RESET_PC(RST_PC), .FLUSH_CYCLES(1)) u_dut_a (
    .clk_i(clk_i), .rstn_i(rstn_i), .stall_i(stall_i), .br_valid_i(br_valid_i),
    .branch_i(branch_i), .jump_i(jump_i), .brj_pc_i(brj_pc_i),
    .imem_req_o(req_a), .imem_addr_o(addr_a), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(iv_a), .instr_o(instr_a), .instr_pc_o(ipc_a),
    .flush_o(flush_a), .pc_o(pc_a));

  core_fetch_redirect_ctrl #(.DATA_WIDTH(32), .RESET_PC(RST_PC), .FLUSH_CYCLES(3)) u_dut_b (
    .clk_i(clk_i), .rstn_i(rstn_i), .stall_i(stall_i), .br_valid_i(br_valid_i),
    .branch_i(branch_i), .jump_i(jump_i), .brj_pc_i(brj_pc_i),
    .imem_req_o(req_b), .imem_addr_o(addr_b), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(iv_b), .instr_o(instr_b), .instr_pc_o(ipc_b),
    .flush_o(flush_b), .pc_o(pc_b));

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic        gnt_en = 1'b0;
  logic        mem_clr = 1'b0;
  int          rv_lat = 1;
  logic        pend_v = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_w = 0;

  assign imem_gnt_i    = gnt_en;
  assign imem_rvalid_i = pend_v && (pend_w == 0);
  assign imem_rdata_i  = pend_v ? mem_word(pend_addr) : 32'hDEAD_BEEF;

  always @(posedge clk_i) begin
    if (mem_clr) begin
      pend_v <= 1'b0;
    end else if (req_a && imem_gnt_i) begin
      pend_v    <= 1'b1;
      pend_addr <= addr_a;
      pend_w    <= rv_lat - 1;
    end else if (imem_rvalid_i) begin
      pend_v <= 1'b0;
    end else if (pend_v && pend_w > 0) begin
      pend_w <= pend_w - 1;
    end
  end

  // ---------------- fetch model ----------------
  typedef struct { logic [31:0] pc; bit stale; } ost_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } ins_t;

  bit          m_ok = 1'b0;
  bit          m_started;
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_iv;
  int          m_cnt_a, m_cnt_b;
  ost_t        m_ost[$];
  ins_t        m_skid[$];

  task automatic model_step();
    bit          redir, dlv, req;
    logic [31:0] tgt, nxt;
    ost_t        e;
    ins_t        ne;
    if (!rstn_i) begin
      m_ok = 1'b1; m_started = 1'b0; m_pc = RST_PC;
      m_ost.delete(); m_skid.delete();
      m_iv = 1'b0; m_instr = '0; m_ipc = '0; m_cnt_a = 0; m_cnt_b = 0;
    end else if (m_ok) begin
      redir = br_valid_i && (branch_i || jump_i) && !stall_i;
      tgt   = brj_pc_i & ~32'h3;
      req   = m_started && m_ost.size() == 0 && m_skid.size() == 0;
      dlv   = 1'b0;
      ne    = '{pc: '0, word: '0};
      if (m_ost.size() != 0 && imem_rvalid_i) begin
        e = m_ost.pop_front();
        if (!e.stale && !redir) begin
          dlv = 1'b1; ne.pc = e.pc; ne.word = mem_word(e.pc);
        end
      end
      nxt = m_pc;
      if (req && imem_gnt_i) begin
        m_ost.push_back('{pc: m_pc, stale: redir});
        nxt = m_pc + 32'd4;
      end
      if (redir) begin
        foreach (m_ost[i]) m_ost[i].stale = 1'b1;
        nxt = tgt;
      end
      m_started = 1'b1;
      if (redir) begin
        m_iv = 1'b0; m_skid.delete();
      end else if (!stall_i) begin
        if (m_skid.size() != 0) begin
          ne = m_skid.pop_front(); m_iv = 1'b1; m_instr = ne.word; m_ipc = ne.pc;
        end else if (dlv) begin
          m_iv = 1'b1; m_instr = ne.word; m_ipc = ne.pc;
        end else begin
          m_iv = 1'b0;
        end
      end else if (dlv) begin
        if (m_iv) m_skid.push_back(ne);
        else begin m_iv = 1'b1; m_instr = ne.word; m_ipc = ne.pc; end
      end
      if (redir) begin m_cnt_a = 1; m_cnt_b = 3; end
      else begin
        if (m_cnt_a > 0) m_cnt_a--;
        if (m_cnt_b > 0) m_cnt_b--;
      end
      m_pc = nxt;
    end
  endtask

  always @(posedge clk_i) begin
    bit m_req;
    model_step();
    #1;
    if (m_ok) begin
      m_req = m_started && m_ost.size() == 0 && m_skid.size() == 0;
      cmp("req_a", req_a, m_req);
      cmp("req_b", req_b, m_req);
      if (m_req) begin
        cmp("addr_a", addr_a, m_pc);
        cmp("addr_b", addr_b, m_pc);
      end
      cmp("pc_a", pc_a, m_pc);
      cmp("pc_b", pc_b, m_pc);
      cmp("ivalid_a", iv_a, m_iv);
      cmp("ivalid_b", iv_b, m_iv);
      cmp("instr_a", instr_a, m_instr);
      cmp("instr_b", instr_b, m_instr);
      cmp("ipc_a", ipc_a, m_ipc);
      cmp("ipc_b", ipc_b, m_ipc);
      cmp("flush_a", flush_a, m_cnt_a != 0);
      cmp("flush_b", flush_b, m_cnt_b != 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic set_br(input logic v, input logic b, input logic j, input logic [31:0] t);
    br_valid_i = v; branch_i = b; jump_i = j; brj_pc_i = t;
  endtask

  task automatic chk_reset(input string nm);
    cmp({nm, "_req"}, req_a, 0);
    cmp({nm, "_iv"}, iv_a, 0);
    cmp({nm, "_instr"}, instr_a, 0);
    cmp({nm, "_ipc"}, ipc_a, 0);
    cmp({nm, "_flush_a"}, flush_a, 0);
    cmp({nm, "_flush_b"}, flush_b, 0);
    cmp({nm, "_pc"}, pc_a, RST_PC);
  endtask

  task automatic reset_dut();
    rstn_i = 1'b0; mem_clr = 1'b1; gnt_en = 1'b0; rv_lat = 1; stall_i = 1'b0;
    set_br(0, 0, 0, 32'h0);
    repeat (3) tick();
    chk_reset("rst");
    rstn_i = 1'b1; mem_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got_addr[$];
    logic [31:0] got_pc[$];

    // Streaming fetch: grant always, data one cycle later.
    reset_dut(); gnt_en = 1'b1; rv_lat = 1;
    repeat (8) begin
      tick();
      if (req_a) got_addr.push_back(addr_a);
      if (iv_a) got_pc.push_back(ipc_a);
    end
    cmp("t1_nreq", got_addr.size(), 4);
    cmp("t1_ndeliv", got_pc.size(), 3);
    if (got_addr.size() >= 3 && got_pc.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        cmp("t1_addr", got_addr[i], 32'(i * 4));
        cmp("t1_ipc", got_pc[i], 32'(i * 4));
      end

    // Taken branch in RESP before rvalid; pending word is dropped.
    reset_dut(); gnt_en = 1'b1; rv_lat = 3;
    tick(); tick();
    set_br(1, 1, 0, 32'h103); gnt_en = 1'b0;
    tick();
    set_br(0, 0, 0, 32'h0);
    cmp("t2_pc", pc_a, 32'h100); cmp("t2_flush_a", flush_a, 1);
    cmp("t2_flush_b", flush_b, 1); cmp("t2_req", req_a, 0);
    tick();
    cmp("t2_flush_a_end", flush_a, 0); cmp("t2_flush_b_hold", flush_b, 1);
    tick();
    cmp("t2_req2", req_a, 1); cmp("t2_addr2", addr_a, 32'h100); cmp("t2_iv", iv_a, 0);
    gnt_en = 1'b1; rv_lat = 1;
    tick(); gnt_en = 1'b0;
    tick();
    cmp("t2_iv2", iv_a, 1); cmp("t2_ipc2", ipc_a, 32'h100); cmp("t2_instr2", instr_a, mem_word(32'h100));

    // Ungranted request redirected by a jump.
    reset_dut();
    repeat (3) begin tick(); cmp("t3_req", req_a, 1); cmp("t3_addr", addr_a, 32'h0); end
    tick(); set_br(1, 0, 1, 32'h40);
    tick(); set_br(0, 0, 0, 32'h0);
    cmp("t3_addr_j", addr_a, 32'h40); cmp("t3_req_j", req_a, 1); cmp("t3_flush", flush_a, 1);
    gnt_en = 1'b1;
    tick(); gnt_en = 1'b0; cmp("t3_req_resp", req_a, 0);
    tick();
    cmp("t3_iv", iv_a, 1); cmp("t3_ipc", ipc_a, 32'h40); cmp("t3_instr", instr_a, mem_word(32'h40));

    // Stall for 4 cycles while the next word returns into the skid buffer.
    reset_dut(); gnt_en = 1'b1; rv_lat = 1;
    tick(); tick(); tick();
    cmp("t4_iv0", iv_a, 1); cmp("t4_ipc0", ipc_a, 32'h0);
    stall_i = 1'b1;
    tick();
    tick();
    cmp("t4_hold_iv", iv_a, 1); cmp("t4_hold_ipc", ipc_a, 32'h0);
    cmp("t4_hold_instr", instr_a, mem_word(32'h0)); cmp("t4_req_blk", req_a, 0);
    tick(); cmp("t4_req_blk2", req_a, 0);
    tick(); stall_i = 1'b0; cmp("t4_hold_ipc2", ipc_a, 32'h0);
    tick();
    cmp("t4_skid_iv", iv_a, 1); cmp("t4_skid_ipc", ipc_a, 32'h4);
    cmp("t4_skid_instr", instr_a, mem_word(32'h4));
    cmp("t4_req_res", req_a, 1); cmp("t4_addr_res", addr_a, 32'h8);
    tick(); cmp("t4_iv_gap", iv_a, 0);
    tick(); cmp("t4_iv8", iv_a, 1); cmp("t4_ipc8", ipc_a, 32'h8);
    gnt_en = 1'b0;

    // Redirect with rvalid, redirect in RESP, redirect again in DROP.
    reset_dut(); gnt_en = 1'b1; rv_lat = 1;
    tick();
    tick(); set_br(1, 0, 1, 32'h200);
    tick(); set_br(0, 0, 0, 32'h0); rv_lat = 3;
    cmp("t5_iv", iv_a, 0); cmp("t5_req", req_a, 1); cmp("t5_addr", addr_a, 32'h200);
    tick(); set_br(1, 0, 1, 32'h300); gnt_en = 1'b0;
    tick(); set_br(1, 1, 0, 32'h343); cmp("t5_req_drop", req_a, 0);
    tick(); set_br(0, 0, 0, 32'h0); rv_lat = 1;
    cmp("t5_pc", pc_a, 32'h340); cmp("t5_flush_a", flush_a, 1);
    cmp("t5_flush_b", flush_b, 1); cmp("t5_req_drop2", req_a, 0);
    tick();
    cmp("t5_req2", req_a, 1); cmp("t5_addr2", addr_a, 32'h340); cmp("t5_iv2", iv_a, 0);
    cmp("t5_flush_a_end", flush_a, 0); cmp("t5_flush_b2", flush_b, 1);
    gnt_en = 1'b1;
    tick(); gnt_en = 1'b0; cmp("t5_flush_b3", flush_b, 1);
    tick();
    cmp("t5_flush_b_end", flush_b, 0); cmp("t5_iv3", iv_a, 1);
    cmp("t5_ipc3", ipc_a, 32'h340); cmp("t5_instr3", instr_a, mem_word(32'h340));

    // Reset mid-RESP near the top of memory; abandoned response ignored.
    reset_dut();
    tick(); set_br(1, 0, 1, 32'hFFFF_FFF8);
    tick(); set_br(0, 0, 0, 32'h0); gnt_en = 1'b1; rv_lat = 3;
    cmp("t6_pc", pc_a, 32'hFFFF_FFF8);
    tick(); gnt_en = 1'b0; cmp("t6_pc_resp", pc_a, 32'hFFFF_FFFC); rstn_i = 1'b0;
    tick(); rstn_i = 1'b1; chk_reset("t6_rst");
    tick(); cmp("t6_req", req_a, 1); cmp("t6_addr", addr_a, RST_PC);
    tick(); cmp("t6_iv_stale", iv_a, 0); cmp("t6_req2", req_a, 1); cmp("t6_addr2", addr_a, RST_PC);
    gnt_en = 1'b1; rv_lat = 1;
    tick(); gnt_en = 1'b0;
    tick(); cmp("t6_iv", iv_a, 1); cmp("t6_ipc", ipc_a, RST_PC); cmp("t6_instr", instr_a, mem_word(RST_PC));

    // PC wrap: fetch at 0xFFFF_FFFC, next address is 0.
    reset_dut();
    tick(); set_br(1, 0, 1, 32'hFFFF_FFFC);
    tick(); set_br(0, 0, 0, 32'h0); gnt_en = 1'b1; rv_lat = 1;
    cmp("t7_req", req_a, 1); cmp("t7_addr", addr_a, 32'hFFFF_FFFC);
    tick(); cmp("t7_pc_wrap", pc_a, 32'h0);
    tick();
    cmp("t7_iv", iv_a, 1); cmp("t7_ipc", ipc_a, 32'hFFFF_FFFC);
    cmp("t7_instr", instr_a, mem_word(32'hFFFF_FFFC));
    cmp("t7_req2", req_a, 1); cmp("t7_addr2", addr_a, 32'h0);
    tick(); gnt_en = 1'b0;
    tick(); cmp("t7_iv2", iv_a, 1); cmp("t7_ipc2", ipc_a, 32'h0);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_fetch_redirect_ctrl.md
# core_fetch_redirect_ctrl

Fetch-side sequencer that owns the program counter and drives the instruction-memory request interface. It consumes the decode-stage branching unit's decision (`branch`, target PC) and the jump flag, then redirects fetch. It discards wrong-path responses, buffers one response under stall, and pulses a pipeline flush. It sits between the instruction memory and the IF/ID register, feeding `instr_o` and `instr_pc_o` to decode.

## Interface
- `DATA_WIDTH`, 32, width of PC, addresses and instruction words.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `FLUSH_CYCLES`, 1, length of the `flush_o` pulse in cycles (1..7).

Ports:
- `clk_i`  in  1  clock, all logic on rising edge.
- `rstn_i`  in  1  **reset, synchronous, active-low.**
- `stall_i`  in  1  decode stall from hazard logic; the output instruction slot must hold.
- `br_valid_i`  in  1  decode holds a valid branch/JAL/JALR this cycle.
- `branch_i`  in  1  branch condition true, from the branching unit.
- `jump_i`  in  1  unconditional JAL/JALR.
- `brj_pc_i`  in  DATA_WIDTH  redirect target from the branching unit.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  DATA_WIDTH  fetch address, word aligned.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  read data valid; arrives 1 or more cycles after the grant.
- `imem_rdata_i`  in  DATA_WIDTH  instruction word.
- `instr_valid_o`  out  1  `instr_o` holds a valid instruction.
- `instr_o`  out  DATA_WIDTH  instruction to decode.
- `instr_pc_o`  out  DATA_WIDTH  PC of `instr_o`.
- `flush_o`  out  1  kill younger pipeline contents.
- `pc_o`  out  DATA_WIDTH  current fetch PC register.

## Operation
- Redirect event: `redir = br_valid_i & (branch_i | jump_i) & ~stall_i`. Target is `{brj_pc_i[DATA_WIDTH-1:2], 2'b00}`.
- At most one request is outstanding. The state register has four states: IDLE, REQ, RESP, DROP.
- IDLE:
  - This is the state while `rstn_i=0`; `imem_req_o=0`.
  - Moves to REQ on the first cycle with `rstn_i=1`.
- REQ:
  - `imem_req_o=1` and `imem_addr_o=pc` only when the skid buffer is empty; otherwise `imem_req_o=0`.
  - `gnt & ~redir`: `pc<=pc+4`, latch the request PC, go to RESP.
  - `gnt & redir`: `pc<=target`, go to DROP.
  - `~gnt & redir`: `pc<=target`, stay in REQ. The address may change while ungranted; imem tolerates this.
- RESP:
  - `rvalid & ~redir`: deliver the word with its latched PC, go to REQ.
  - `rvalid & redir`: discard the word, `pc<=target`, go to REQ.
  - `~rvalid & redir`: `pc<=target`, go to DROP.
- DROP:
  - On `rvalid`: discard the word, go to REQ.
  - On `redir`: `pc<=target`, stay in DROP.
- Delivery with `stall_i=0` loads `instr_o`, `instr_pc_o` and `instr_valid_o=1`.
- Delivery with `stall_i=1` and `instr_valid_o=1` writes the one-entry skid buffer.
- When `stall_i` deasserts, the skid buffer moves to the output register. The skid buffer takes priority over a new delivery, which cannot occur because REQ is blocked while the skid is full.
- With no delivery and `stall_i=0`, `instr_valid_o<=0`.
- On `redir`:
  - Next cycle, `instr_valid_o=0` and the skid buffer is cleared.
  - The flush counter loads `FLUSH_CYCLES`; `flush_o=(cnt!=0)`.
  - The counter decrements each cycle and restarts on a new `redir`.
- Arithmetic: `pc+4` is modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - state IDLE, `pc=RESET_PC`, `pc_o=RESET_PC`.
  - `imem_req_o=0`, `instr_valid_o=0`, `instr_o=0`, `instr_pc_o=0`.
  - `flush_o=0`, flush counter 0, skid buffer empty.
- Reset asserted mid-transaction returns to IDLE. A later `rvalid` for the abandoned request is ignored in IDLE and REQ.
- First request: `imem_req_o=1` with `RESET_PC` one cycle after `rstn_i` rises.
- Best-case throughput is 1 instruction per 2 cycles, with `gnt` in REQ and `rvalid` the next cycle.
- Fetch-to-output latency: `instr_valid_o` rises the cycle after `rvalid`.
- Redirect at cycle t:
  - `pc_o=target` at t+1.
  - `flush_o=1` for cycles t+1 .. t+FLUSH_CYCLES.
  - If no request is outstanding, a target request is issued at t+1.
- `redir` is ignored while `stall_i=1`; decode re-presents it after the stall.
- `imem_req_o`, `imem_addr_o` and `pc_o` are registered-state functions. `imem_req_o` does not depend combinationally on `imem_gnt_i`.

## Test plan
- Reset, then constant `gnt=1` with `rvalid` one cycle later -> requests at addresses 0x0, 0x4, 0x8 every 2 cycles; `instr_pc_o` sequence 0x0, 0x4, 0x8.
- Taken branch (`br_valid_i=1`, `branch_i=1`, `brj_pc_i=0x103`) in RESP before `rvalid` -> pending word discarded; next request address 0x100; `flush_o` high exactly 1 cycle; no instruction from the old path appears.
- Hold `gnt` low for 3 cycles, then JAL redirect to 0x40 while still ungranted -> `imem_addr_o` switches to 0x40 and the grant fetches 0x40.
- `stall_i=1` for 4 cycles while a word returns -> `instr_o` holds; the new word goes to skid; `imem_req_o=0`; after release the skid is delivered, then fetch resumes at the next PC.
- Redirect and `rvalid` in the same cycle, plus a second redirect in DROP -> both stale words discarded; final fetch uses the last target; the flush counter restarts (FLUSH_CYCLES=3 gives 3-cycle pulse from the last redirect).
- Pull `rstn_i` low for 1 cycle during RESP, with `pc` at 0xFFFF_FFFC -> all outputs return to reset values and fetch restarts at `RESET_PC`. In a separate run, a fetch at 0xFFFF_FFFC wraps the next address to 0x0.
